led_breath_pwm: RTL and testbench

Breathing PWM driver sitting directly downstream of the one-hot LED selector. It consumes the 8-bit one-hot `led_select` and drives the board LEDs. Each time the selected LED changes, that LED runs one brightness cycle: a triangle rise, a hold at peak, a fall, then stays dark. All other LEDs stay off.

---
 rtl/led_breath_pwm.sv | 122 ++++++++++++
 tb/tb_led_breath_pwm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/led_breath_pwm.sv
// Breathing PWM LED driver: each change of the one-hot select runs one
// rise / hold-at-peak / fall brightness cycle on the selected LED, then goes dark.
module led_breath_pwm #(
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 4,
   parameter int HOLD_STEPS   = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] led_select,
   output logic [7:0] led
);

   localparam int PERIOD_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam int HOLD_W   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   localparam logic [PWM_BITS-1:0] MAX         = '1;
   localparam logic [PWM_BITS-1:0] MAX_M1      = MAX - 1'b1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE    = 1;
   localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(STEP_PERIODS - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE,
      RISE,
      PEAK,
      FALL,
      DARK
   } state_t;

   state_t              state;
   logic [7:0]          sel_q;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PERIOD_W-1:0] period_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [HOLD_W-1:0]   hold_cnt;

   logic valid;
   logic restart;
   logic pwm_wrap;
   logic step;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign valid    = (led_select != 8'h00) &&
                     ((led_select & (led_select - 8'd1)) == 8'h00);
   assign restart  = valid && (led_select != sel_q);
   assign pwm_wrap = (pwm_cnt == MAX);
   assign step     = pwm_wrap && (period_cnt == PERIOD_LAST);

   // NOTE: every register, including led, is cleared by the asynchronous reset
   // and updated only with non-blocking assignments so all reads see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel_q      <= 8'h00;
         pwm_cnt    <= '0;
         period_cnt <= '0;
         duty       <= '0;
         hold_cnt   <= '0;
         led        <= 8'h00;
      end else begin
         sel_q <= led_select;

         if (!valid) begin
            state      <= IDLE;
            pwm_cnt    <= '0;
            period_cnt <= '0;
            duty       <= '0;
            hold_cnt   <= '0;
            led        <= 8'h00;
         end else if (restart) begin
            state      <= RISE;
            pwm_cnt    <= '0;
            period_cnt <= '0;
            duty       <= '0;
            hold_cnt   <= '0;
            led        <= 8'h00;
         end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap) begin
               period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
            end

            // Duty only moves on a period boundary, so each PWM period is glitch-free.
            led <= led_select & {8{pwm_cnt < duty}};

            if (step) begin
               case (state)
                  RISE: begin
                     duty <= duty + 1'b1;
                     if (duty == MAX_M1) begin
                        state <= PEAK;
                     end
                  end
                  PEAK: begin
                     if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        duty     <= MAX_M1;
                        state    <= FALL;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
                  FALL: begin
                     duty <= duty - 1'b1;
                     if (duty == DUTY_ONE) begin
                        state <= DARK;
                     end
                  end
                  DARK: begin
                     duty <= '0;
                  end
                  default: begin
                     state <= state;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Scoreboard bench for led_breath_pwm (PWM_BITS=3, STEP_PERIODS=1, HOLD_STEPS=2):
// stimulus pushes expected led values, a monitor pops and compares each cycle.
module tb_led_breath_pwm;

   localparam int PWM_BITS     = 3;
   localparam int STEP_PERIODS = 1;
   localparam int HOLD_STEPS   = 2;
   localparam int BREATH_HIGH  = 56;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] led_select = 8'h00;
   logic [7:0] led;

   led_breath_pwm #(
      .PWM_BITS    (PWM_BITS),
      .STEP_PERIODS(STEP_PERIODS),
      .HOLD_STEPS  (HOLD_STEPS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .led_select(led_select),
      .led       (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    bit_idx;
      int    expected;
      int    base;
      string name;
   } cnt_req_t;

   logic [7:0] exp_q[$];
   cnt_req_t   cnt_q[$];
   int         hi_cnt[8];
   int         checks = 0;
   int         errors = 0;
   logic       done = 1'b0;
   string      scenario = "reset";

   // Bench-side view of the breath: select last seen, and cycles since restart.
   logic [7:0] m_sel = 8'h00;
   logic       active = 1'b0;
   int         k = 0;

   // Closed-form breath profile: period p has duty 0..6 rising, 7 for two
   // peak periods, 6..1 falling, then 0; led is high while phase < duty.
   function automatic logic [7:0] breath_led(input int kk, input logic [7:0] sel);
      int p, ph, d;
      p  = (kk - 1) / 8;
      ph = (kk - 1) % 8;
      if (p < 7)       d = p;
      else if (p < 9)  d = 7;
      else if (p < 15) d = 15 - p;
      else             d = 0;
      return (ph < d) ? sel : 8'h00;
   endfunction

   task automatic cycle(input logic [7:0] sel);
      logic [7:0] e;
      led_select = sel;
      if (!$onehot(sel)) begin
         e      = 8'h00;
         active = 1'b0;
      end else if (sel != m_sel) begin
         e      = 8'h00;
         active = 1'b1;
         k      = 0;
      end else begin
         if (active) k++;
         e = active ? breath_led(k, sel) : 8'h00;
      end
      m_sel = sel;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic [7:0] sel, input int n);
      for (int i = 0; i < n; i++) cycle(sel);
   endtask

   task automatic expect_cnt(input int b, input int base, input string name);
      cnt_req_t r;
      r.bit_idx  = b;
      r.expected = BREATH_HIGH;
      r.base     = base;
      r.name     = name;
      cnt_q.push_back(r);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s] t=%0t: led=%h required=%h", name, scenario, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s [%s]: got %0d required %0d", name, scenario, act, exp);
      end
   endtask

   // Monitor: per-cycle led compare, per-bit high counters, async-reset check.
   initial begin
      logic [7:0] e;
      cnt_req_t   r;
      logic       rst_prev;
      int         drain;
      rst_prev = 1'b0;
      drain    = 0;
      for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (rst_prev && !rst_n) begin
            #1;
            check("async_reset_led", led, 8'h00);
         end else begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("led", led, e);
            end
            for (int i = 0; i < 8; i++) hi_cnt[i] += int'(led[i]);
            while (cnt_q.size() > 0) begin
               r = cnt_q.pop_front();
               check_int(r.name, hi_cnt[r.bit_idx] - r.base, r.expected);
            end
            if (done) begin
               drain++;
               if (exp_q.size() == 0 && cnt_q.size() == 0) begin
                  $display("CHECKS %0d ERRORS %0d", checks, errors);
                  $finish;
               end else if (drain > 20) begin
                  check_int("drain_pending", exp_q.size() + cnt_q.size(), 0);
                  $display("CHECKS %0d ERRORS %0d", checks, errors);
                  $finish;
               end
            end
         end
         rst_prev = rst_n;
      end
   end

   // Stimulus
   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;

      // Full breath and peak duty on led[0] straight out of reset.
      scenario = "full_breath";
      rst_n = 1'b1;
      base = hi_cnt[0];
      run(8'h01, 130);
      expect_cnt(0, base, "breath_high_led0");

      // Mid-breath restart onto led[1] at cycle 40.
      scenario = "mid_restart";
      run(8'h00, 2);
      base = hi_cnt[1];
      run(8'h01, 40);
      run(8'h02, 130);
      expect_cnt(1, base, "restart_high_led1");

      // Multi-hot select during RISE, then a fresh breath on led[1].
      scenario = "invalid_select";
      run(8'h01, 20);
      run(8'h03, 10);
      base = hi_cnt[1];
      run(8'h02, 130);
      expect_cnt(1, base, "invalid_high_led1");

      // Asynchronous reset between edges while in PEAK.
      scenario = "async_reset";
      run(8'h01, 60);
      #6;
      rst_n  = 1'b0;
      m_sel  = 8'h00;
      active = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         exp_q.push_back(8'h00);
      end
      rst_n = 1'b1;
      base = hi_cnt[0];
      run(8'h01, 130);
      expect_cnt(0, base, "post_reset_high_led0");

      // Rotation sweep 02 -> ... -> 80 -> 01, 200 cycles each.
      scenario = "rotation";
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] sel;
         int         b;
         b    = i % 8;
         sel  = 8'h01 << b;
         base = hi_cnt[b];
         run(sel, 200);
         expect_cnt(b, base, "rotation_high");
      end

      done = 1'b1;
   end

endmodule
